emesh_tx_packer: RTL and testbench

Upstream feeder for the elink transmit system interface. Accepts host transaction commands over a valid/ready port and packs each into a 104-bit emesh packet. Routes writes to the `txwr` channel and reads to the `txrd` channel. Buffers each channel in its own FIFO and honours the elink `*_wait` backpressure.

---
 rtl/emesh_pkg.sv | 24 ++
 rtl/emesh_tx_packer_if.sv | 17 +
 rtl/emesh_pkt_fifo.sv | 34 +++
 rtl/emesh_tx_packer.sv | 59 +++++
 tb/tb_emesh_tx_packer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/emesh_pkg.sv
// emesh_pkg: emesh packet layout, datamode encoding and pack/alignment helpers.
package emesh_pkg;
  localparam int PKT_W    = 104;
  localparam int WRITE_LSB = 0;
  localparam int DM_LSB   = 1;
  localparam int DM_W     = 2;
  localparam int CM_LSB   = 3;
  localparam int CM_W     = 5;
  localparam int DST_LSB  = 8;
  localparam int DATA_LSB = 40;
  localparam int SRC_LSB  = 72;
  localparam int ADDR_W   = 32;
  typedef enum logic [1:0] {DM_BYTE = 2'd0, DM_HALF = 2'd1, DM_WORD = 2'd2, DM_DOUBLE = 2'd3} datamode_e;
  function automatic logic [PKT_W-1:0] emesh_pack(input logic write, input logic [DM_W-1:0] datamode,
      input logic [CM_W-1:0] ctrlmode, input logic [ADDR_W-1:0] dstaddr, input logic [ADDR_W-1:0] data,
      input logic [ADDR_W-1:0] srcaddr);
    return {srcaddr, data, dstaddr, ctrlmode, datamode, write};
  endfunction
  function automatic logic emesh_aligned(input logic [DM_W-1:0] datamode, input logic [ADDR_W-1:0] addr);
    return datamode == DM_DOUBLE ? addr[2:0] == 3'd0 :
           datamode == DM_WORD   ? addr[1:0] == 2'd0 :
           datamode == DM_HALF   ? !addr[0] : 1'b1;
  endfunction
endpackage

// File: rtl/emesh_tx_packer_if.sv
// emesh_tx_packer_if: host command port plus the two elink transmit channels.
interface emesh_tx_packer_if;
  import emesh_pkg::*;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [1:0]       cmd_datamode;
  logic [4:0]       cmd_ctrlmode;
  logic [31:0]      cmd_dstaddr, cmd_data, cmd_srcaddr;
  logic             txwr_access, txwr_wait, txrd_access, txrd_wait;
  logic [PKT_W-1:0] txwr_packet, txrd_packet;
  logic             err_misaligned;
  modport slave (input cmd_valid, cmd_write, cmd_datamode, cmd_ctrlmode, cmd_dstaddr, cmd_data, cmd_srcaddr,
                 txwr_wait, txrd_wait,
                 output cmd_ready, txwr_access, txwr_packet, txrd_access, txrd_packet, err_misaligned);
  modport master (output cmd_valid, cmd_write, cmd_datamode, cmd_ctrlmode, cmd_dstaddr, cmd_data, cmd_srcaddr,
                  txwr_wait, txrd_wait,
                  input cmd_ready, txwr_access, txwr_packet, txrd_access, txrd_packet, err_misaligned);
endinterface

// File: rtl/emesh_pkt_fifo.sv
// emesh_pkt_fifo: first-word-fall-through packet FIFO; head reads as zero while empty.
module emesh_pkt_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push, w_pop;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty = r_wp == r_rp;
  assign o_head  = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_push);
      r_rp <= r_rp + (AW+1)'(w_pop);
    end
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/emesh_tx_packer.sv
// emesh_tx_packer: packs host commands into emesh packets and queues them on txwr/txrd.
// Define EMESH_TX_PACKER_STATS_EN to add transfer and drop counters.
module emesh_tx_packer
  import emesh_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              resetb,
  emesh_tx_packer_if.slave bus
`ifdef EMESH_TX_PACKER_STATS_EN
  ,
  output logic [31:0]      stat_wr_sent,
  output logic [31:0]      stat_rd_sent,
  output logic [15:0]      stat_drops
`endif
);
  logic             w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
  logic             w_accept, w_aligned, w_pop_wr, w_pop_rd;
  logic [PKT_W-1:0] w_pkt;
  logic             r_err;
  // Readiness looks only at the selected FIFO's full flag, never at this cycle's pop.
  assign bus.cmd_ready      = bus.cmd_write ? !w_wr_full : !w_rd_full;
  assign w_accept           = bus.cmd_valid && bus.cmd_ready;
  assign w_aligned          = emesh_aligned(bus.cmd_datamode, bus.cmd_dstaddr);
  assign w_pkt              = emesh_pack(bus.cmd_write, bus.cmd_datamode, bus.cmd_ctrlmode,
                                         bus.cmd_dstaddr, bus.cmd_data, bus.cmd_srcaddr);
  assign w_pop_wr           = !w_wr_empty && !bus.txwr_wait;
  assign w_pop_rd           = !w_rd_empty && !bus.txrd_wait;
  assign bus.txwr_access    = !w_wr_empty;
  assign bus.txrd_access    = !w_rd_empty;
  assign bus.err_misaligned = r_err;
  emesh_pkt_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_wr_fifo (
    .clock(clock), .resetb(resetb), .i_push(w_accept && w_aligned && bus.cmd_write), .i_data(w_pkt),
    .i_pop(w_pop_wr), .o_full(w_wr_full), .o_empty(w_wr_empty), .o_head(bus.txwr_packet));
  emesh_pkt_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_rd_fifo (
    .clock(clock), .resetb(resetb), .i_push(w_accept && w_aligned && !bus.cmd_write), .i_data(w_pkt),
    .i_pop(w_pop_rd), .o_full(w_rd_full), .o_empty(w_rd_empty), .o_head(bus.txrd_packet));
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) r_err <= 1'b0;
    else r_err <= w_accept && !w_aligned;
`ifdef EMESH_TX_PACKER_STATS_EN
  logic [31:0] r_wr_sent, r_rd_sent;
  logic [15:0] r_drops;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      r_wr_sent <= '0;
      r_rd_sent <= '0;
      r_drops   <= '0;
    end else begin
      r_wr_sent <= r_wr_sent + 32'(w_pop_wr);
      r_rd_sent <= r_rd_sent + 32'(w_pop_rd);
      if (w_accept && !w_aligned && r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
    end
  assign stat_wr_sent = r_wr_sent;
  assign stat_rd_sent = r_rd_sent;
  assign stat_drops   = r_drops;
`endif
endmodule

// File: tb/tb_emesh_tx_packer.sv
// tb_emesh_tx_packer: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_emesh_tx_packer;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;
  emesh_tx_packer_if bus();
`ifdef EMESH_TX_PACKER_STATS_EN
  logic [31:0] stat_wr_sent, stat_rd_sent;
  logic [15:0] stat_drops;
`endif
  emesh_tx_packer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .resetb(resetb), .bus(bus)
`ifdef EMESH_TX_PACKER_STATS_EN
    , .stat_wr_sent(stat_wr_sent), .stat_rd_sent(stat_rd_sent), .stat_drops(stat_drops)
`endif
  );
  int n_vec = 0, n_err = 0;
  logic [103:0] m_wr[$], m_rd[$];
  bit m_err = 0;
  int unsigned m_wsent = 0, m_rsent = 0, m_drops = 0, obs_wr = 0;
  typedef struct {
    bit v, w; bit [1:0] dm; bit [31:0] dst, data;
    bit rdy, wa, ra, err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, logic [103:0] act, logic [103:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, bit w, bit [1:0] dm, bit [4:0] cm, bit [31:0] dst, bit [31:0] data,
                       bit [31:0] src, bit ww, bit rw);
    bus.cmd_valid = v; bus.cmd_write = w; bus.cmd_datamode = dm; bus.cmd_ctrlmode = cm;
    bus.cmd_dstaddr = dst; bus.cmd_data = data; bus.cmd_srcaddr = src;
    bus.txwr_wait = ww; bus.txrd_wait = rw;
  endtask

  // One clock cycle: check readiness, let the edge happen, advance the model, check the outputs.
  task automatic tick(output bit accepted);
    bit rdy, al, popw, popr;
    logic [103:0] pkt;
    #1;
    rdy = bus.cmd_write ? (m_wr.size() < DEPTH) : (m_rd.size() < DEPTH);
    chk("cmd_ready", {103'd0, bus.cmd_ready}, {103'd0, rdy});
    accepted = bus.cmd_valid && rdy;
    al = (bus.cmd_dstaddr % (32'd1 << bus.cmd_datamode)) == 0;
    pkt = {bus.cmd_srcaddr, bus.cmd_data, bus.cmd_dstaddr, bus.cmd_ctrlmode, bus.cmd_datamode, bus.cmd_write};
    popw = m_wr.size() > 0 && !bus.txwr_wait;
    popr = m_rd.size() > 0 && !bus.txrd_wait;
    if (bus.txwr_access && !bus.txwr_wait) obs_wr++;
    @(posedge clock);
    if (popw) begin void'(m_wr.pop_front()); m_wsent++; end
    if (popr) begin void'(m_rd.pop_front()); m_rsent++; end
    if (accepted && al) begin
      if (bus.cmd_write) m_wr.push_back(pkt);
      else m_rd.push_back(pkt);
    end
    m_err = accepted && !al;
    if (m_err && m_drops < 65535) m_drops++;
    #1;
    chk("txwr_access", {103'd0, bus.txwr_access}, {103'd0, m_wr.size() > 0});
    chk("txrd_access", {103'd0, bus.txrd_access}, {103'd0, m_rd.size() > 0});
    chk("txwr_packet", bus.txwr_packet, m_wr.size() > 0 ? m_wr[0] : 104'd0);
    chk("txrd_packet", bus.txrd_packet, m_rd.size() > 0 ? m_rd[0] : 104'd0);
    chk("err_misaligned", {103'd0, bus.err_misaligned}, {103'd0, m_err});
`ifdef EMESH_TX_PACKER_STATS_EN
    chk("stat_wr_sent", {72'd0, stat_wr_sent}, {72'd0, m_wsent});
    chk("stat_rd_sent", {72'd0, stat_rd_sent}, {72'd0, m_rsent});
    chk("stat_drops", {88'd0, stat_drops}, {88'd0, m_drops[15:0]});
`endif
  endtask

  initial begin
    bit acc;
    logic [103:0] first;
    int got;
    tbl[0] = '{1, 1, 2, 32'h80800000, 32'hDEADBEEF, 1, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 32'h0,        32'h0,        1, 0, 0, 0};
    tbl[2] = '{1, 1, 3, 32'h80800004, 32'h11111111, 1, 0, 0, 1};
    tbl[3] = '{0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 32'h00000001, 32'h22222222, 1, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0};
    tbl[6] = '{1, 0, 1, 32'h00000003, 32'h33333333, 1, 0, 0, 1};
    tbl[7] = '{1, 1, 1, 32'h00000002, 32'h44444444, 1, 1, 0, 0};
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_ready", {103'd0, bus.cmd_ready}, 104'd1);
    chk("reset_wr_acc", {103'd0, bus.txwr_access}, 104'd0);
    chk("reset_err", {103'd0, bus.err_misaligned}, 104'd0);
    repeat (2) @(posedge clock);
    #1 resetb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].dm, 0, tbl[i].dst, tbl[i].data, 0, 0, 0);
      #1;
      chk("tbl_ready", {103'd0, bus.cmd_ready}, {103'd0, tbl[i].rdy});
      tick(acc);
      chk("tbl_wr_acc", {103'd0, bus.txwr_access}, {103'd0, tbl[i].wa});
      chk("tbl_rd_acc", {103'd0, bus.txrd_access}, {103'd0, tbl[i].ra});
      chk("tbl_err", {103'd0, bus.err_misaligned}, {103'd0, tbl[i].err});
      if (i == 0) chk("single_pkt", bus.txwr_packet, 104'h00000000_DEADBEEF_80800000_05);
    end
`ifdef EMESH_TX_PACKER_STATS_EN
    chk("tbl_drops", {88'd0, stat_drops}, 104'd2);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(acc);
    // Backpressure: 6 write offers against a stalled channel; only DEPTH fit.
    got = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2, 5'(i), 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 32'(i), 1, 0);
      tick(acc);
      if (acc) got++;
      if (i == 0) first = bus.txwr_packet;
    end
    chk("bp_accepted", 104'(got), 104'd4);
    chk("bp_ready_low", {103'd0, bus.cmd_ready}, 104'd0);
    chk("bp_head_stable", bus.txwr_packet, first);
    // Independence: reads flow while the write channel is stalled and full.
    drive(1, 0, 2, 0, 32'h2000, 32'hB000, 32'hC000, 1, 0);
    tick(acc);
    chk("ind_rd0_acc", 104'(acc), 104'd1);
    drive(1, 0, 2, 0, 32'h2004, 32'hB001, 32'hC004, 1, 0);
    tick(acc);
    chk("ind_rd1_acc", 104'(acc), 104'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(acc);
    tick(acc);
    chk("ind_rd_drained", {103'd0, bus.txrd_access}, 104'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick(acc);
    chk("bp_drained", {103'd0, bus.txwr_access}, 104'd0);
    // Reset with three packets queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 32'h3000 + 32'(i), 32'(i), 0, 1, 0);
      tick(acc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3 resetb = 1'b0;
    #1;
    chk("rst_wr_acc", {103'd0, bus.txwr_access}, 104'd0);
    chk("rst_wr_pkt", bus.txwr_packet, 104'd0);
    chk("rst_rd_acc", {103'd0, bus.txrd_access}, 104'd0);
    chk("rst_ready", {103'd0, bus.cmd_ready}, 104'd1);
    m_wr.delete(); m_rd.delete(); m_err = 0; m_wsent = 0; m_rsent = 0; m_drops = 0;
    @(posedge clock);
    #1 resetb = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick(acc);
    // 20 writes with wait toggling every cycle; host holds each command until accepted.
    obs_wr = 0;
    got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      drive(1, 1, 2, 0, 32'h4000 + 32'(got * 4), 32'h5000 + 32'(got), 0, c[0], 0);
      tick(acc);
      if (acc) got++;
    end
    for (int c = 0; c < 50 && m_wr.size() > 0; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, c[0], 0);
      tick(acc);
    end
    chk("wrap_accepted", 104'(got), 104'd20);
    chk("wrap_sent", 104'(obs_wr), 104'd20);
    chk("wrap_empty", {103'd0, bus.txwr_access}, 104'd0);
`ifdef EMESH_TX_PACKER_STATS_EN
    chk("wrap_stat", {72'd0, stat_wr_sent}, 104'd20);
`endif
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      tick(acc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
